// File: rtl/dp_ram_fifo_sdp_ram_core.sv
// Simple dual-port RAM: one write port and one registered read port.
// Ports: clk, we/waddr/wdata write side, re/raddr read side, rdata registered.
module sdp_ram_core #(
    parameter int AW = 3,
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [1<<AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dp_ram_fifo.sv
// Synchronous FIFO controller around sdp_ram_core with sticky error flags.
// Ports: clk, rst_n, wr_en/wr_data, rd_en/rd_data/rd_valid, full, empty, count, overflow, underflow.
module dp_ram_fifo #(
    parameter int AW = 3,
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam int          DP      = 1 << AW;
    localparam logic [AW:0] DP_CNT  = (AW + 1)'(DP);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          rd_valid_q, rd_valid_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    // Set by the first accepted read after reset; the RAM's read register
    // has no reset, so rd_data is forced to zero until it holds a real word.
    logic          primed_q, primed_d;
    logic          wr_acc, rd_acc;
    logic [DW-1:0] ram_rdata;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign wr_acc   = wr_en && !full;
    assign rd_acc   = rd_en && !empty;

    assign rd_valid  = rd_valid_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign rd_data   = primed_q ? ram_rdata : '0;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_acc;
        ovf_d      = ovf_q || (wr_en && full);
        udf_d      = udf_q || (rd_en && empty);
        primed_d   = primed_q || rd_acc;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            primed_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            primed_q   <= primed_d;
        end
    end

    sdp_ram_core #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr_q[AW-1:0]),
        .wdata(wr_data),
        .re   (rd_acc),
        .raddr(rd_ptr_q[AW-1:0]),
        .rdata(ram_rdata)
    );

    logic unused_dp;
    assign unused_dp = (count > DP_CNT);

endmodule
